ysyx_25060166_fetch_ctrl: RTL
=============================

Name: ysyx_25060166_fetch_ctrl

Overview:
Multi-cycle instruction fetch controller for the RV32E core; replaces the free-running PC counter and feeds the decode stage.
- Issues word reads to instruction memory over a valid/ready request channel with a separate response channel.
- Holds each fetched instruction with its PC until decode accepts it.
- Applies jump/branch redirects from execute, discarding stale responses.

Parameters:
WIDTH, 32, data/address width (matches ysyx_25060166_WIDTH)
RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  WIDTH  fetch word address
mem_rsp_valid  in  1  read data valid (single-cycle pulse per accepted request)
mem_rsp_data  in  WIDTH  instruction word
mem_rsp_err  in  1  bus error for this response
inst_valid  out  1  instruction held for decode
inst_ready  in  1  decode consumes instruction
inst_data  out  WIDTH  held instruction
inst_pc  out  WIDTH  PC of held instruction
inst_err  out  1  held instruction had bus error
redirect_valid  in  1  jump/branch taken
redirect_pc  in  WIDTH  redirect target

Behaviour:
- Reset values: mem_req_valid=0, mem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, inst_err=0, state=IDLE, drop=0, pend=0.
- IDLE: entered only on reset. First clk edge after rst deasserts -> REQ.
- REQ: mem_req_valid=1.
  - mem_req_addr stays stable until mem_req_valid && mem_req_ready.
  - On acceptance -> WAIT; the address is latched as fetch_pc.
- WAIT: mem_req_valid=0. On mem_rsp_valid:
  - drop=0: capture data, err and fetch_pc into inst_*; -> HOLD (inst_valid=1 the next cycle).
  - drop=1: discard the response, clear drop; -> REQ with addr = pend_target, clear pend.
- HOLD: inst_valid=1 and inst_* stable until handshake.
  - inst_valid && inst_ready: inst_valid=0 next cycle; -> REQ with addr = redirect_pc if redirect_valid this cycle, else inst_pc+4.
- Redirect without handshake:
  - In HOLD: held instruction discarded (inst_valid=0 next cycle); -> REQ at redirect_pc.
  - In REQ or WAIT: outstanding or about-to-issue request must still complete with its address unchanged; set drop=1, pend=1, pend_target=redirect_pc.
  - Repeated redirects before the drop completes: last target wins.
  - In REQ, redirect and acceptance in the same cycle: request issues at the old address and drop=1.
- Latency: reset release -> mem_req_valid in 1 cycle. Zero-wait memory gives accept->rsp 1 cycle, rsp->inst_valid 1 cycle; minimum 3 cycles per instruction.
- PC arithmetic is modulo 2^WIDTH; 32'hFFFF_FFFC+4 wraps to 0.
- mem_rsp_valid outside WAIT is ignored (protocol violation, flag in assertions).
- rst asserted mid-transaction: all state returns to reset values immediately. A response arriving after reset release but before the new request is accepted is ignored, because the FSM is not yet in WAIT.
- inst_err is passed through only; the block takes no trap action.

Optional Feature:
YSYX_25060166_FETCH_ALIGN_CHECK_EN
- Defined: redirect_pc[1:0]!=0 is not fetched.
  - The block presents a pseudo-instruction: inst_valid=1, inst_pc=redirect_pc, inst_data=0, inst_err=1.
  - After that handshake it returns to REQ at redirect_pc+4 with low bits cleared.
  - Counts as a redirect for drop purposes.
- Undefined: redirect_pc[1:0] is forced to 0 and the fetch proceeds normally; no error is raised.

Test Plan:
- Reset release, zero-wait memory, inst_ready=1 -> mem_req_addr sequence 8000_0000, 8000_0004, 8000_0008; inst_pc matches each; 3 cycles per instruction.
- mem_req_ready low 4 cycles -> mem_req_addr held at 8000_0000 throughout; single acceptance.
- inst_ready low 5 cycles in HOLD -> inst_data/inst_pc stable; no new request issued; fetch continues after the handshake.
- Redirect to 8000_0100 while in WAIT for 8000_0004 -> response for 8000_0004 never reaches inst_valid; next request 8000_0100.
- Handshake plus redirect to 8000_0040 in same cycle -> held instruction consumed once; next request 8000_0040. Separately, mem_rsp_err=1 -> inst_err=1 with the correct inst_pc.
- rst pulsed low while in WAIT -> outputs back to reset values; next request at RESET_PC; the late response is ignored.

Source files
------------

// File: rtl/ysyx_25060166_fetch_ctrl.sv
// Multi-cycle instruction fetch controller: one outstanding word read, one held instruction for decode.
// Define YSYX_25060166_FETCH_ALIGN_CHECK_EN to turn misaligned redirects into bus-error pseudo-instructions.
module ysyx_25060166_fetch_ctrl #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [WIDTH-1:0] mem_rsp_data,
    input  logic             mem_rsp_err,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst_data,
    output logic [WIDTH-1:0] inst_pc,
    output logic             inst_err,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc
);

    localparam logic [WIDTH-1:0] WORD_MASK = WIDTH'(3);
    localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(4);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] req_addr_q, req_addr_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] inst_data_q, inst_data_d;
    logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic             inst_err_q, inst_err_d;
    logic             drop_q, drop_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic             pend_mis_q, pend_mis_d;

    logic [WIDTH-1:0] redir_target;
    logic             redir_misalign;
    logic             jump;
    logic [WIDTH-1:0] jump_pc;
    logic             jump_mis;

`ifdef YSYX_25060166_FETCH_ALIGN_CHECK_EN
    assign redir_target   = redirect_pc;
    assign redir_misalign = (redirect_pc & WORD_MASK) != '0;
`else
    assign redir_target   = redirect_pc & ~WORD_MASK;
    assign redir_misalign = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        fetch_pc_d    = fetch_pc_q;
        inst_data_d   = inst_data_q;
        inst_pc_d     = inst_pc_q;
        inst_err_d    = inst_err_q;
        drop_d        = drop_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        pend_mis_d    = pend_mis_q;
        jump          = 1'b0;
        jump_pc       = redir_target;
        jump_mis      = redir_misalign;

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                // The request address never changes once presented; a redirect only arms the drop.
                if (mem_req_ready) begin
                    fetch_pc_d = req_addr_q;
                    state_d    = StWait;
                end
                if (redirect_valid) begin
                    drop_d        = 1'b1;
                    pend_d        = 1'b1;
                    pend_target_d = redir_target;
                    pend_mis_d    = redir_misalign;
                end
            end
            StWait: begin
                if (mem_rsp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d     = 1'b0;
                        pend_d     = 1'b0;
                        pend_mis_d = 1'b0;
                        jump       = 1'b1;
                        // A redirect in the response cycle is newer than the pending one.
                        if (!redirect_valid && pend_q) begin
                            jump_pc  = pend_target_q;
                            jump_mis = pend_mis_q;
                        end
                    end else begin
                        inst_data_d = mem_rsp_data;
                        inst_err_d  = mem_rsp_err;
                        inst_pc_d   = fetch_pc_q;
                        state_d     = StHold;
                    end
                end else if (redirect_valid) begin
                    drop_d        = 1'b1;
                    pend_d        = 1'b1;
                    pend_target_d = redir_target;
                    pend_mis_d    = redir_misalign;
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    jump = 1'b1;
                end else if (inst_ready) begin
                    // Masking realigns after a misaligned pseudo-instruction; wraps modulo 2^WIDTH.
                    req_addr_d = (inst_pc_q + PC_STEP) & ~WORD_MASK;
                    state_d    = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        if (jump) begin
            if (jump_mis) begin
                inst_pc_d   = jump_pc;
                inst_data_d = '0;
                inst_err_d  = 1'b1;
                state_d     = StHold;
            end else begin
                req_addr_d = jump_pc;
                state_d    = StReq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            req_addr_q    <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            inst_data_q   <= '0;
            inst_pc_q     <= '0;
            inst_err_q    <= 1'b0;
            drop_q        <= 1'b0;
            pend_q        <= 1'b0;
            pend_target_q <= '0;
            pend_mis_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            fetch_pc_q    <= fetch_pc_d;
            inst_data_q   <= inst_data_d;
            inst_pc_q     <= inst_pc_d;
            inst_err_q    <= inst_err_d;
            drop_q        <= drop_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
            pend_mis_q    <= pend_mis_d;
        end
    end

    assign mem_req_valid = (state_q == StReq);
    assign mem_req_addr  = req_addr_q;
    assign inst_valid    = (state_q == StHold);
    assign inst_data     = inst_data_q;
    assign inst_pc       = inst_pc_q;
    assign inst_err      = inst_err_q;

`ifdef FORMAL
    a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst)
        mem_rsp_valid |-> state_q == StWait);
    a_req_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        (mem_req_valid && !mem_req_ready) |=> (mem_req_valid && $stable(mem_req_addr)));
    a_inst_stable: assert property (@(posedge clk) disable iff (!rst)
        (inst_valid && !inst_ready && !redirect_valid) |=>
        (inst_valid && $stable(inst_pc) && $stable(inst_data) && $stable(inst_err)));
`endif

endmodule
